// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB tag width, default unit count and the broadcast
// payload type seen by the ROB, reservation stations and read-port bypass.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_WIDTH   = 6;
  localparam int unsigned CDB_DATA_W  = 32;
  localparam int unsigned N_CDB_UNITS = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned STALL_W     = 32;

  // Common data bus broadcast payload
  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

  // Pointer width for an n-way round-robin arbiter (n >= 2)
  function automatic int unsigned rr_ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin picker. Scans req starting at ptr
// and wrapping explicitly at N; returns one-hot grant, its index and a hit flag.
// Shared with the issue-side arbiter.
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N = N_CDB_UNITS,
  localparam int unsigned PTR_W = rr_ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  localparam int unsigned CAND_W = PTR_W + 1;

  logic [CAND_W-1:0] cand;

  // First requester at or after ptr, wrapping by subtraction rather than modulo
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CAND_W'(k);
      if (cand >= CAND_W'(N)) begin
        cand = cand - CAND_W'(N);
      end
      if (!any && req[cand[PTR_W-1:0]]) begin
        grant[cand[PTR_W-1:0]] = 1'b1;
        idx                    = cand[PTR_W-1:0];
        any                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one execution unit per cycle (round-robin) and broadcasts
// the granted result on a registered CDB one cycle later.
// Optional build macro CDB_ARBITER_PERF_EN adds stall_cycles and per-unit
// grant_count performance counters (saturating).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_UNITS = N_CDB_UNITS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [N_UNITS-1:0]                    req_valid,
  output logic [N_UNITS-1:0]                    req_ready,
  input  logic [N_UNITS-1:0][ROB_WIDTH-1:0]     req_tag,
  input  logic [N_UNITS-1:0][CDB_DATA_W-1:0]    req_data,
  output cdb_t                                  cdb
`ifdef CDB_ARBITER_PERF_EN
  ,
  output logic [STALL_W-1:0]                    stall_cycles,
  output logic [N_UNITS-1:0][CNT_W-1:0]         grant_count
`endif
);

  localparam int unsigned PTR_W = rr_ptr_width(N_UNITS);

  logic [PTR_W-1:0]   rr_ptr;
  logic [N_UNITS-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               xfer;

  rr_pick #(
    .N (N_UNITS)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready is withheld during flush and while reset is asserted
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    if (rst_n && !flush) begin
      req_ready = pick_grant;
      xfer      = pick_any;
    end
  end

  // Broadcast register and round-robin pointer advance on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb    <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      cdb.valid <= 1'b1;
      cdb.tag   <= req_tag[pick_idx];
      cdb.data  <= req_data[pick_idx];
      rr_ptr    <= (pick_idx == PTR_W'(N_UNITS - 1)) ? '0 : pick_idx + PTR_W'(1);
    end else begin
      cdb.valid <= 1'b0;
    end
  end

`ifdef CDB_ARBITER_PERF_EN
  logic any_stall;

  // A cycle stalls when some requester is left waiting outside a flush
  always_comb begin
    any_stall = !flush && (|(req_valid & ~req_ready));
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (any_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

  // Saturating per-unit transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
    end else begin
      for (int unsigned u = 0; u < N_UNITS; u++) begin
        if (xfer && (pick_idx == PTR_W'(u)) && (grant_count[u] != '1)) begin
          grant_count[u] <= grant_count[u] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Responder side of the per-unit cdb_req valid/ready handshake.
- Each execution unit raises cdb_req.valid with its result (ROB tag plus 32-bit data). The arbiter grants one unit per cycle with round-robin priority and broadcasts the granted result on the registered common data bus (cdb_t) one cycle later.
- Sits between the execution units and every CDB consumer (ROB, reservation stations, register-read bypass).

Parameters:
- N_UNITS, 4, number of requesting units; legal range 2..8.
- PTR_W, $clog2(N_UNITS), width of the round-robin pointer; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; discards in-flight broadcast and blocks grants this cycle.
- req_valid  in  N_UNITS  per-unit cdb_req.valid.
- req_ready  out  N_UNITS  per-unit cdb_req.ready (one-hot or zero).
- req_tag  in  N_UNITS x ROB_WIDTH  per-unit result.tag.
- req_data  in  N_UNITS x 32  per-unit result.data.
- cdb  out  cdb_t  broadcast {valid, tag[ROB_WIDTH-1:0], data[31:0]}.

Behaviour:
- Reset (async, rst_n=0): cdb.valid=0, cdb.tag=0, cdb.data=0, rr_ptr=0. req_ready is combinational and therefore 0 while flush=1 or no requests.
- Grant: combinational. Search indices rr_ptr, rr_ptr+1, … modulo N_UNITS. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. A unit holds valid, tag and data stable until transfer. Ready never depends on data.
- Broadcast: on transfer, the next clk edge loads cdb <= {1, req_tag[i], req_data[i]}. With no transfer, cdb.valid <= 0 and tag/data hold. Latency is exactly 1 cycle; throughput is 1 result per cycle.
- Pointer: on transfer, rr_ptr <= (i==N_UNITS-1) ? 0 : i+1. Without transfer it holds. Wrap-around is explicit; no modulo on non-power-of-2 counts.
- Fairness: a continuously requesting unit is granted within N_UNITS cycles.
- flush=1: all req_ready=0, cdb.valid <= 0 next edge, rr_ptr holds. Units must drop requests themselves.
- Simultaneous events:
  - flush overrides any grant.
  - A single requester equal to rr_ptr is granted immediately.
  - All units valid: grant rr_ptr.
- Reset mid-transfer: the broadcast is lost; cdb.valid=0 immediately (async).
- No internal buffering beyond the single output register. Back-pressure to units is via ready only; CDB consumers never stall.

Optional Feature:
- Macro: CDB_ARBITER_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits), reset 0.
  - Increments by 1 on each cycle where any unit has req_valid=1 & req_ready=0, flush=0.
  - Saturates at 32'hFFFF_FFFF.
  - Adds output grant_count (N_UNITS x 16), per-unit transfer counters, saturating, reset 0.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package (with common.vh constants) holds:
  - cdb_t struct {valid; tag[ROB_WIDTH-1:0]; data[31:0]}, already used by read ports.
  - ROB_WIDTH, and N_UNITS default as a constant N_CDB_UNITS.
- One sub-module: rr_pick. Inputs: N-bit request vector and pointer. Outputs: one-hot grant and encoded index. Purely combinational, reusable for the issue-side arbiter.

Test Plan:
- Reset with req_valid=4'b1111 → cdb.valid=0, req_ready=0000 while rst_n=0. After release, req_ready=0001 and next cycle cdb={1, tag0, data0}.
- All four valid, continuously, tags 1..4 → ready sequence 0001,0010,0100,1000,0001. CDB shows tags 1,2,3,4,1 each one cycle after grant; no bubbles.
- rr_ptr=3, only unit 1 valid (tag 5, data 32'hDEAD_BEEF) → req_ready=0010. Next cycle cdb={1,5,DEADBEEF}; rr_ptr becomes 2.
- flush asserted in a cycle with units 0 and 2 valid → req_ready=0000. Next cycle cdb.valid=0 and rr_ptr unchanged. After flush, grant resumes at the old pointer.
- rst_n dropped mid-cycle while cdb.valid=1 → cdb.valid=0 immediately without a clock edge; rr_ptr=0.
- With CDB_ARBITER_PERF_EN, units 0..3 valid for 5 cycles → stall_cycles=5 and grant_count of each unit ≥1. Without the macro the bench compiles with the counter ports absent.
